ysyx_20020207_icache: RTL

//   Direct-mapped, read-only instruction cache between the IFU fetch port and the IFU side of the arbiter.

---
 rtl/ysyx_20020207_icache_if.sv | 32 +++
 rtl/ysyx_20020207_icache.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ysyx_20020207_icache_if.sv
`default_nettype none
// ============================================================================
// Module : ysyx_20020207_icache_if
// AXI4 read-channel subset linking the IFU, the I-cache and the arbiter.
// Rev    : 1.0
// ============================================================================
interface ysyx_20020207_icache_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  rvalid;
  logic                  rready;
  logic [63:0]           rdata;
  logic [1:0]            rresp;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp
  );

  // The IFU never varies the burst fields, so the cache does not look at them.
  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_20020207_icache.sv
`default_nettype none
// ============================================================================
// Module : ysyx_20020207_icache
// Direct-mapped, one-word-line, read-only I-cache with single-beat refill.
// Rev    : 1.0
// ============================================================================
module ysyx_20020207_icache #(
  parameter int INDEX_BITS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  ysyx_20020207_icache_if.slave  s,
  ysyx_20020207_icache_if.master m,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_MISS_AR = 3'd2,
    S_MISS_R  = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  flushed_q, flushed_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [31:0]           hit_cnt_q, hit_cnt_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           line_q [LINES];

  logic                  fill_we;
  logic                  hit;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [31:0]           fill_word;

  assign idx       = addr_q[INDEX_BITS+1:2];
  assign tag       = addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
  assign fill_word = addr_q[2] ? m.rdata[63:32] : m.rdata[31:0];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);

  assign s.rdata   = {data_q, data_q};
  assign s.rresp   = rresp_q;
  assign m.araddr  = addr_q;
  assign m.arlen   = 8'd0;
  assign m.arsize  = 3'b010;
  assign m.arburst = 2'b01;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rresp_d    = rresp_q;
    flushed_d  = flushed_q;
    valid_d    = valid_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    fill_we    = 1'b0;
    s.arready  = 1'b0;
    s.rvalid   = 1'b0;
    m.arvalid  = 1'b0;
    m.rready   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        s.arready = 1'b1;
        if (s.arvalid) begin
          addr_d    = s.araddr;
          flushed_d = 1'b0;
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          data_d    = line_q[idx];
          rresp_d   = 2'b00;
          hit_cnt_d = hit_cnt_q + 32'd1;
          state_d   = S_RESP;
        end else begin
          miss_cnt_d = miss_cnt_q + 32'd1;
          state_d    = S_MISS_AR;
        end
      end
      S_MISS_AR: begin
        m.arvalid = 1'b1;
        if (m.arready) state_d = S_MISS_R;
      end
      S_MISS_R: begin
        m.rready = 1'b1;
        if (m.rvalid) begin
          data_d  = fill_word;
          rresp_d = m.rresp;
          // A flush seen now or earlier in this miss makes the fill stale.
          fill_we = (m.rresp == 2'b00) && !flushed_q && !flush && !reset;
          if (fill_we) valid_d[idx] = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        s.rvalid = 1'b1;
        if (s.rready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      valid_d = '0;
      if (state_q == S_LOOKUP || state_q == S_MISS_AR || state_q == S_MISS_R)
        flushed_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      rresp_q    <= '0;
      flushed_q  <= 1'b0;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rresp_q    <= rresp_d;
      flushed_q  <= flushed_d;
      valid_q    <= valid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (fill_we) begin
      tag_q[idx]  <= tag;
      line_q[idx] <= fill_word;
    end
  end
endmodule
`default_nettype wire
